// File: rtl/sysarr_output_collector.sv
// -----------------------------------------------------------------------------
// sysarr_output_collector
//
// Collects the N output rows of one systolic-array result tile into a
// ping-pong pair of tile banks (rows may arrive in any order), then writes
// each completed tile back as N row beats over a valid/ready handshake.
// While one bank fills, the other may drain.
//
// Ports:
//   clk            clock
//   RST            synchronous active-high reset
//   out_en         array output row valid this cycle
//   row_out        row index of array_output
//   array_output   row data, element 0 in the MSBs
//   tile_base_addr writeback base address of the tile being filled
//   wr_valid       writeback beat valid
//   wr_ready       memory accepts the beat
//   wr_addr        beat address (0 when wr_valid is low)
//   wr_data        beat data    (0 when wr_valid is low)
//   wr_last        final beat (row N-1) of a tile
//   collector_full stall request: the fill bank cannot accept a row
//   tile_done      one-cycle pulse after the last beat of a tile handshakes
//   dup_err        sticky: a row index was written twice into one fill
//   ovf_err        sticky: a row was dropped
//   busy           any bank not EMPTY
// -----------------------------------------------------------------------------
module sysarr_output_collector #(
  parameter int N          = 4,
  parameter int DW         = 16,
  parameter int AW         = 16,
  parameter int ROW_STRIDE = 1,
  localparam int RW        = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            RST,
  input  logic            out_en,
  input  logic [RW-1:0]   row_out,
  input  logic [N*DW-1:0] array_output,
  input  logic [AW-1:0]   tile_base_addr,
  output logic            wr_valid,
  input  logic            wr_ready,
  output logic [AW-1:0]   wr_addr,
  output logic [N*DW-1:0] wr_data,
  output logic            wr_last,
  output logic            collector_full,
  output logic            tile_done,
  output logic            dup_err,
  output logic            ovf_err,
  output logic            busy
);

  typedef enum logic [1:0] {
    B_EMPTY,
    B_FILLING,
    B_READY,
    B_DRAINING
  } bank_state_e;

  typedef enum logic {
    D_IDLE,
    D_DRAIN
  } drain_state_e;

  // Per-bank bookkeeping
  bank_state_e     bank_state [2];
  logic [N-1:0]    bank_map   [2];
  logic [AW-1:0]   bank_base  [2];
  logic [N*DW-1:0] bank_mem   [2][N];

  logic            fill_bank;
  logic            drain_bank;
  drain_state_e    drain_state;
  logic [RW-1:0]   k;
  logic            tile_done_q;
  logic            dup_q;
  logic            ovf_q;

  // Fill-side decode
  logic            row_ok;
  logic            fill_open;
  logic            fill_accept;
  logic            fill_drop;
  logic [N-1:0]    row_onehot;
  logic [N-1:0]    prev_map;
  logic [N-1:0]    new_map;
  logic            fill_dup;
  logic            fill_complete;

  // Drain-side decode
  logic            drain_start;
  logic            beat_last;

  // Only reachable when N is not a power of two.
  assign row_ok    = int'(row_out) < N;
  assign fill_open = (bank_state[fill_bank] == B_EMPTY) ||
                     (bank_state[fill_bank] == B_FILLING);

  assign fill_accept = out_en && fill_open && row_ok;
  assign fill_drop   = out_en && !fill_accept;

  // NOTE: every signal assigned in always_comb gets a default first so no
  // path leaves it unassigned and a latch cannot be inferred.
  always_comb begin
    row_onehot = '0;
    row_onehot[row_out] = 1'b1;
  end

  // A bank that is EMPTY holds a stale bitmap from its previous tile.
  assign prev_map      = (bank_state[fill_bank] == B_EMPTY) ? '0 : bank_map[fill_bank];
  assign new_map       = prev_map | row_onehot;
  assign fill_dup      = fill_accept && |(prev_map & row_onehot);
  assign fill_complete = fill_accept && &new_map;

  // Start draining either a bank already READY, or the bank completing at
  // this very edge so the first beat appears one cycle after the last row.
  assign drain_start = (drain_state == D_IDLE) &&
                       ((bank_state[drain_bank] == B_READY) ||
                        (fill_complete && (fill_bank == drain_bank)));

  assign beat_last = (k == RW'(N - 1));

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (RST) begin
      for (int b = 0; b < 2; b++) begin
        bank_state[b] <= B_EMPTY;
        bank_map[b]   <= '0;
        bank_base[b]  <= '0;
      end
      fill_bank   <= 1'b0;
      drain_bank  <= 1'b0;
      drain_state <= D_IDLE;
      k           <= '0;
      tile_done_q <= 1'b0;
      dup_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      // Fill side
      if (fill_accept) begin
        bank_map[fill_bank] <= new_map;
        if (bank_state[fill_bank] == B_EMPTY) begin
          bank_base[fill_bank]  <= tile_base_addr;
          bank_state[fill_bank] <= B_FILLING;
        end
        if (fill_complete) begin
          bank_state[fill_bank] <= B_READY;
          fill_bank             <= ~fill_bank;
        end
      end
      dup_q <= dup_q | fill_dup;
      ovf_q <= ovf_q | fill_drop;

      // Drain side; placed after the fill updates so that a bank completing
      // and starting to drain at the same edge ends up DRAINING.
      tile_done_q <= 1'b0;
      case (drain_state)
        D_IDLE: begin
          if (drain_start) begin
            bank_state[drain_bank] <= B_DRAINING;
            k                      <= '0;
            drain_state            <= D_DRAIN;
          end
        end
        D_DRAIN: begin
          if (wr_ready) begin
            if (beat_last) begin
              bank_state[drain_bank] <= B_EMPTY;
              drain_bank             <= ~drain_bank;
              tile_done_q            <= 1'b1;
              k                      <= '0;
              drain_state            <= D_IDLE;
            end else begin
              k <= k + 1'b1;
            end
          end
        end
        default: drain_state <= D_IDLE;
      endcase
    end
  end

  // NOTE: the tile storage has no reset; every row is written before it can
  // be read, and the bitmap/state registers carry all the validity.
  always_ff @(posedge clk) begin
    if (!RST && fill_accept) begin
      bank_mem[fill_bank][row_out] <= array_output;
    end
  end

  // Outputs
  assign wr_valid       = (drain_state == D_DRAIN);
  assign wr_addr        = wr_valid ? (bank_base[drain_bank] + AW'(k) * AW'(ROW_STRIDE)) : '0;
  assign wr_data        = wr_valid ? bank_mem[drain_bank][k] : '0;
  assign wr_last        = wr_valid && beat_last;
  assign collector_full = (bank_state[fill_bank] == B_READY) ||
                          (bank_state[fill_bank] == B_DRAINING);
  assign tile_done      = tile_done_q;
  assign dup_err        = dup_q;
  assign ovf_err        = ovf_q;
  assign busy           = (bank_state[0] != B_EMPTY) || (bank_state[1] != B_EMPTY);

endmodule

// File: tb/tb_sysarr_output_collector.sv
// -----------------------------------------------------------------------------
// Testbench for sysarr_output_collector. A tile-level reference model (a
// queue of completed tiles, at most two held, plus the tile being filled)
// predicts every output each cycle.
// -----------------------------------------------------------------------------
module tb_sysarr_output_collector;

  localparam int N          = 4;
  localparam int DW         = 16;
  localparam int AW         = 16;
  localparam int ROW_STRIDE = 1;
  localparam int RW         = 2;

  logic            clk = 1'b0;
  logic            RST;
  logic            out_en;
  logic [RW-1:0]   row_out;
  logic [N*DW-1:0] array_output;
  logic [AW-1:0]   tile_base_addr;
  logic            wr_valid;
  logic            wr_ready;
  logic [AW-1:0]   wr_addr;
  logic [N*DW-1:0] wr_data;
  logic            wr_last;
  logic            collector_full;
  logic            tile_done;
  logic            dup_err;
  logic            ovf_err;
  logic            busy;

  sysarr_output_collector #(
    .N(N), .DW(DW), .AW(AW), .ROW_STRIDE(ROW_STRIDE)
  ) dut (
    .clk            (clk),
    .RST            (RST),
    .out_en         (out_en),
    .row_out        (row_out),
    .array_output   (array_output),
    .tile_base_addr (tile_base_addr),
    .wr_valid       (wr_valid),
    .wr_ready       (wr_ready),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .wr_last        (wr_last),
    .collector_full (collector_full),
    .tile_done      (tile_done),
    .dup_err        (dup_err),
    .ovf_err        (ovf_err),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  typedef struct packed {
    logic [AW-1:0]             base;
    logic [N-1:0][N*DW-1:0]    rows;
  } tile_t;

  tile_t        m_q[$];      // completed tiles not yet fully written back
  tile_t        m_fill = '0; // tile being gathered
  logic [N-1:0] m_mask = '0; // rows gathered so far
  bit           m_active = 1'b0;
  int           m_j = 0;
  bit           m_done = 1'b0;
  bit           m_dup = 1'b0;
  bit           m_ovf = 1'b0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Applies one clock edge to the model using the inputs present at that edge.
  task automatic model_edge();
    bit hs;
    if (RST) begin
      m_q.delete();
      m_mask   = '0;
      m_active = 1'b0;
      m_j      = 0;
      m_done   = 1'b0;
      m_dup    = 1'b0;
      m_ovf    = 1'b0;
      return;
    end
    m_done = 1'b0;
    hs     = m_active && wr_ready;
    // Two tiles held means the fill bank is the older held tile: drop.
    if (out_en) begin
      if (m_q.size() == 2 || int'(row_out) >= N) begin
        m_ovf = 1'b1;
      end else begin
        if (m_mask == '0) m_fill.base = tile_base_addr;
        if (m_mask[row_out]) m_dup = 1'b1;
        m_mask[row_out]      = 1'b1;
        m_fill.rows[row_out] = array_output;
        if (&m_mask) begin
          m_q.push_back(m_fill);
          m_mask = '0;
        end
      end
    end
    if (m_active) begin
      if (hs) begin
        if (m_j == N - 1) begin
          void'(m_q.pop_front());
          m_active = 1'b0;
          m_done   = 1'b1;
          m_j      = 0;
        end else begin
          m_j++;
        end
      end
    end else if (m_q.size() > 0) begin
      m_active = 1'b1;
      m_j      = 0;
    end
  endtask

  task automatic compare_outputs();
    logic [AW-1:0]   e_addr;
    logic [N*DW-1:0] e_data;
    logic            e_last;
    e_addr = '0;
    e_data = '0;
    e_last = 1'b0;
    if (m_active) begin
      e_addr = AW'(int'(m_q[0].base) + m_j * ROW_STRIDE);
      e_data = m_q[0].rows[m_j];
      e_last = (m_j == N - 1);
    end
    check("wr_valid",       wr_valid,       m_active);
    check("wr_addr",        wr_addr,        e_addr);
    check("wr_data",        wr_data,        e_data);
    check("wr_last",        wr_last,        e_last);
    check("tile_done",      tile_done,      m_done);
    check("collector_full", collector_full, m_q.size() == 2);
    check("dup_err",        dup_err,        m_dup);
    check("ovf_err",        ovf_err,        m_ovf);
    check("busy",           busy,           (m_q.size() != 0) || (m_mask != '0));
  endtask

  // One clock cycle: drive inputs, take the edge, sample on the falling edge.
  task automatic step(input bit rst, input bit en, input logic [RW-1:0] row,
                      input logic [N*DW-1:0] data, input logic [AW-1:0] base,
                      input bit rdy);
    RST            = rst;
    out_en         = en;
    row_out        = row;
    array_output   = data;
    tile_base_addr = base;
    wr_ready       = rdy;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, '0, rdy);
  endtask

  function automatic logic [N*DW-1:0] rand_row();
    return {$urandom, $urandom};
  endfunction

  task automatic send_row(input logic [RW-1:0] row, input logic [N*DW-1:0] data,
                          input logic [AW-1:0] base, input bit rdy);
    step(1'b0, 1'b1, row, data, base, rdy);
  endtask

  task automatic send_tile(input logic [AW-1:0] base, input bit rdy);
    for (int r = 0; r < N; r++) send_row(RW'(r), rand_row(), base, rdy);
  endtask

  initial begin
    RST = 1'b1; out_en = 1'b0; row_out = '0; array_output = '0;
    tile_base_addr = '0; wr_ready = 1'b0;
    @(negedge clk);

    // Reset state
    step(1'b1, 1'b0, '0, '0, '0, 1'b0);
    step(1'b1, 1'b1, 2'd1, rand_row(), 16'h1234, 1'b1);
    idle(2, 1'b1);

    // Single tile, in-order rows, always ready
    send_tile(16'h0100, 1'b1);
    idle(8, 1'b1);

    // Out-of-order rows, each row holding its own index
    send_row(2'd2, 64'd2, 16'h0200, 1'b1);
    send_row(2'd0, 64'd0, 16'h0200, 1'b1);
    send_row(2'd3, 64'd3, 16'h0200, 1'b1);
    send_row(2'd1, 64'd1, 16'h0200, 1'b1);
    idle(8, 1'b1);

    // Backpressure: stalled, then toggling ready
    send_tile(16'h0300, 1'b0);
    idle(5, 1'b0);
    for (int i = 0; i < 20; i++) idle(1, 1'($urandom_range(0, 1)));
    idle(8, 1'b1);

    // Ping-pong and full: three tiles with writeback stalled
    send_tile(16'h0400, 1'b0);
    send_tile(16'h0500, 1'b0);
    send_tile(16'h0600, 1'b0);
    idle(3, 1'b0);
    idle(14, 1'b1);

    // Duplicate row: second row-1 write carries 0xBEEF
    step(1'b1, 1'b0, '0, '0, '0, 1'b0);
    send_row(2'd0, rand_row(), 16'h0700, 1'b1);
    send_row(2'd1, rand_row(), 16'h0700, 1'b1);
    send_row(2'd1, {4{16'hBEEF}}, 16'h0700, 1'b1);
    send_row(2'd2, rand_row(), 16'h0700, 1'b1);
    send_row(2'd3, rand_row(), 16'h0700, 1'b1);
    idle(8, 1'b1);

    // Address wraps modulo 2^AW
    step(1'b1, 1'b0, '0, '0, '0, 1'b0);
    send_tile(16'hFFFE, 1'b1);
    idle(8, 1'b1);

    // Reset in the middle of the second beat, then a fresh tile
    send_tile(16'h0800, 1'b1);
    idle(1, 1'b1);
    step(1'b1, 1'b0, '0, '0, '0, 1'b1);
    idle(2, 1'b1);
    send_tile(16'h0900, 1'b1);
    idle(8, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      step(1'b0, ($urandom_range(0, 3) != 0), RW'($urandom), rand_row(),
           AW'($urandom), ($urandom_range(0, 2) != 0));
    end
    idle(20, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/sysarr_output_collector.md
Name: sysarr_output_collector

Overview:
- Downstream consumer of the systolic array output port (out_en / row_out / array_output).
- Gathers the N output rows of one result tile into a ping-pong pair of tile banks, in any row order.
- Writes each completed tile back to the scratchpad/memory side as N row beats over a valid/ready handshake.
- Raises a stall request upstream when no bank can accept a new row.

Parameters:
N, 4, array dimension; rows per tile and elements per row
DW, 16, element width in bits
AW, 16, writeback address width
ROW_STRIDE, 1, address increment between consecutive rows of a tile

Ports:
clk  input  1  clock
RST  input  1  reset, synchronous, active-high
out_en  input  1  array output row valid this cycle
row_out  input  $clog2(N)  row index of array_output
array_output  input  N*DW  row data; element 0 in the MSBs
tile_base_addr  input  AW  base address for the tile currently being filled
wr_valid  output  1  writeback beat valid
wr_ready  input  1  memory accepts beat
wr_addr  output  AW  beat address
wr_data  output  N*DW  beat data
wr_last  output  1  final beat (row N-1) of a tile
collector_full  output  1  stall request; fill bank cannot accept a row
tile_done  output  1  one-cycle pulse after the last beat of a tile handshakes
dup_err  output  1  sticky; a row index was written twice into one fill
ovf_err  output  1  sticky; a row was dropped because collector_full was high
busy  output  1  any bank not EMPTY

Behaviour:
- Reset (RST high at a clk edge): both banks EMPTY; fill_bank = 0; drain_bank = 0; drain row counter k = 0.
  - All outputs 0 on the following cycle: wr_valid, wr_last, tile_done, collector_full, dup_err, ovf_err, busy.
  - wr_addr and wr_data read 0 when wr_valid is 0.
  - Bank data storage is not cleared.
  - Reset mid-operation abandons any partial tile and any in-flight beat. No tile_done is issued for it.
- Per-bank state: EMPTY -> FILLING -> READY -> DRAINING -> EMPTY. Each bank has an N-bit row bitmap and a latched base address.
- Fill side, evaluated on out_en, applied to bank[fill_bank]:
  - State EMPTY or FILLING: store array_output at row row_out and set its bitmap bit.
    - If the bank was EMPTY: latch tile_base_addr and go to FILLING.
    - If the bit was already set: overwrite the row data and set dup_err.
    - If the bitmap becomes all ones with this write: the bank goes to READY at that edge and fill_bank toggles.
  - State READY or DRAINING: the row is dropped, ovf_err is set, and no state changes.
- collector_full is combinational from registered state only: high when bank[fill_bank] is READY or DRAINING.
  - A bank that frees at the same edge does not accept that cycle's row. The row is dropped and counted as overflow.
- Drain FSM, states IDLE and DRAIN:
  - IDLE -> DRAIN when bank[drain_bank] is READY. That bank moves to DRAINING and k = 0.
  - Latency: the tile-completing row is registered at edge t; wr_valid is first high in cycle t+1.
  - In DRAIN, wr_valid = 1, wr_data = bank row k, wr_addr = base + k*ROW_STRIDE (modulo 2^AW), wr_last = (k == N-1).
  - Once wr_valid is raised, wr_valid, wr_addr, wr_data and wr_last hold stable until wr_ready is sampled high.
  - On a handshake with k < N-1: k increments.
  - On the last handshake: the bank goes to EMPTY, drain_bank toggles, tile_done pulses high the next cycle, and the FSM returns to IDLE.
    - If the other bank is already READY, it is re-entered on the following cycle, giving one idle cycle between tiles.
- Fill and drain act on different banks and proceed concurrently without interaction.
- A row arriving into the bank that freed this cycle is handled by the collector_full rule above.
- busy = either bank not EMPTY.
- dup_err and ovf_err clear only on reset.
- Width rules:
  - row_out is always within 0..N-1 for N a power of two.
  - For N not a power of two, a row_out >= N is dropped and sets ovf_err.

Test Plan:
- Single tile, in-order rows: N=4, rows 0..3 on consecutive cycles, base 0x0100, wr_ready=1 -> wr_valid rises the cycle after row 3; four beats at 0x0100..0x0103; wr_last on the 4th beat; tile_done one cycle later; busy drops to 0.
- Out-of-order rows: row order 2,0,3,1, each row filled with its index -> beats still emitted in order 0,1,2,3 with matching data; dup_err=0.
- Backpressure: wr_ready low for 5 cycles, then toggling -> each beat holds addr/data/last until its handshake; no beat lost or duplicated.
- Ping-pong and full: three tiles back-to-back with wr_ready=0 -> collector_full rises after tile 2 completes; tile 3 rows are dropped and ovf_err=1. Then raise wr_ready -> tiles 1 and 2 drain in order with their own bases.
- Duplicate row: rows 0,1,1,2,3 with the second row-1 value 0xBEEF -> dup_err=1; the beat for row 1 carries 0xBEEF.
- Reset mid-drain: assert RST during the 2nd beat -> next cycle wr_valid=0, busy=0, errors=0. A fresh tile afterwards drains from row 0 with a correct tile_done.
